// File: rtl/tuser_in_fsm.sv
// Ingress tuser capture: latches AXIS tuser on each packet's SOP transfer and emits a one-cycle tuple-valid pulse.
// Optional statistics counters are compiled in when TUSER_IN_STATS_EN is defined.
module tuser_in_fsm #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128,
    parameter bit CLEAR_DST   = 1'b1
) (
    input  logic                   tin_aclk,
    input  logic                   tin_arst,
    input  logic                   tin_avalid,
    input  logic                   tin_aready,
    input  logic                   tin_alast,
    input  logic [DATA_WIDTH-1:0]  tin_adata,
    input  logic [TUSER_WIDTH-1:0] tin_atuser,
    output logic                   tin_valid,
    output logic [TUSER_WIDTH-1:0] tin_data
`ifdef TUSER_IN_STATS_EN
    ,
    output logic [31:0]            tin_pkt_cnt,
    output logic [15:0]            tin_err_cnt
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;

    // dst_port lives in bits [31:24] of the tuple
    localparam logic [TUSER_WIDTH-1:0] DST_FIELD = {{(TUSER_WIDTH-32){1'b0}}, 8'hFF, 24'h0};
    localparam logic [TUSER_WIDTH-1:0] TUSER_MASK = CLEAR_DST ? ~DST_FIELD : {TUSER_WIDTH{1'b1}};

    logic [0:0]             state, state_nxt;
    logic                   xfer;
    logic                   capture;
    logic [TUSER_WIDTH-1:0] tuser_m;
    logic                   unused_adata;

    assign xfer         = tin_avalid & tin_aready;
    assign capture      = xfer & (state == ST_IDLE);
    assign tuser_m      = tin_atuser & TUSER_MASK;
    assign unused_adata = ^tin_adata;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer && !tin_alast) state_nxt = ST_PKT;
            ST_PKT:  if (xfer && tin_alast)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge tin_aclk) begin
        if (!tin_arst) begin
            state     <= ST_IDLE;
            tin_valid <= 1'b0;
            tin_data  <= '0;
        end else begin
            state     <= state_nxt;
            tin_valid <= capture;
            if (capture) tin_data <= tuser_m;
        end
    end

`ifdef TUSER_IN_STATS_EN
    logic err_hit;

    // Compare in the masked domain so a nonzero dst_port on later beats is not a mismatch
    assign err_hit = xfer & (state == ST_PKT) & ~tin_alast & (tuser_m != tin_data);

    always_ff @(posedge tin_aclk) begin
        if (!tin_arst) begin
            tin_pkt_cnt <= '0;
            tin_err_cnt <= '0;
        end else begin
            if (capture) tin_pkt_cnt <= tin_pkt_cnt + 32'd1;
            if (err_hit) tin_err_cnt <= tin_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tuser_in_fsm.sv
// Scoreboard bench for tuser_in_fsm: stimulus pushes expected tuples, a negedge monitor pops and compares.
// Runs a CLEAR_DST=1 and a CLEAR_DST=0 instance side by side on the same stream.
module tb_tuser_in_fsm;

    logic         clk = 1'b0;
    logic         arst;
    logic         avalid, aready, alast;
    logic [255:0] adata;
    logic [127:0] atuser;
    logic         vld_c, vld_r;
    logic [127:0] dat_c, dat_r;
`ifdef TUSER_IN_STATS_EN
    logic [31:0]  pkt_c, pkt_r;
    logic [15:0]  err_c, err_r;
`endif

    typedef struct {
        int           cyc;
        logic [127:0] clr;
        logic [127:0] raw;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tuser_in_fsm #(.DATA_WIDTH(256), .TUSER_WIDTH(128), .CLEAR_DST(1'b1)) dut (
        .tin_aclk(clk), .tin_arst(arst), .tin_avalid(avalid), .tin_aready(aready),
        .tin_alast(alast), .tin_adata(adata), .tin_atuser(atuser),
        .tin_valid(vld_c), .tin_data(dat_c)
`ifdef TUSER_IN_STATS_EN
        , .tin_pkt_cnt(pkt_c), .tin_err_cnt(err_c)
`endif
    );

    tuser_in_fsm #(.DATA_WIDTH(256), .TUSER_WIDTH(128), .CLEAR_DST(1'b0)) dut_raw (
        .tin_aclk(clk), .tin_arst(arst), .tin_avalid(avalid), .tin_aready(aready),
        .tin_alast(alast), .tin_adata(adata), .tin_atuser(atuser),
        .tin_valid(vld_r), .tin_data(dat_r)
`ifdef TUSER_IN_STATS_EN
        , .tin_pkt_cnt(pkt_r), .tin_err_cnt(err_r)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every tuple pulse must match the head of the queue, in the predicted cycle.
    always @(negedge clk) begin
        exp_t e;
        chk("valid_pair", {127'd0, vld_r}, {127'd0, vld_c});
        if (vld_c === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 128'd1, 128'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", 128'(cyc), 128'(e.cyc));
                chk("tuple_clr", dat_c, e.clr);
                chk("tuple_raw", dat_r, e.raw);
            end
        end
    end

    // Drive one cycle; sop marks a beat that transfers while the DUT is idle.
    task automatic beat(input logic v, input logic r, input logic l, input logic [127:0] tu,
                        input logic sop, input logic [127:0] exp_clr);
        exp_t e;
        avalid = v;
        aready = r;
        alast  = l;
        atuser = tu;
        adata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (sop) begin
            e.cyc = cyc + 1;
            e.clr = exp_clr;
            e.raw = tu;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic pkt(input logic [127:0] tu, input logic [127:0] exp_clr, input int n, input bit chg);
        for (int i = 0; i < n; i++)
            beat(1'b1, 1'b1, (i == n - 1), (chg && i == 1) ? (tu ^ 128'h1) : tu, (i == 0), exp_clr);
    endtask

    initial begin
        arst = 1'b0; avalid = 1'b0; aready = 1'b0; alast = 1'b0; adata = '0; atuser = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_valid", {127'd0, vld_c}, 128'd0);
        chk("rst_data", dat_c, 128'd0);
        chk("rst_data_raw", dat_r, 128'd0);
        arst = 1'b1;
        idle(2);

        // 3-beat packet, dst_port 0x04 cleared
        pkt(128'h0000_0000_0000_0000_0000_00AA_0420_0040,
            128'h0000_0000_0000_0000_0000_00AA_0020_0040, 3, 1'b0);
        idle(3);

        // single-beat packet immediately followed by a 2-beat packet
        pkt(128'h1111_2222_3333_4444_5555_6666_7A01_0203,
            128'h1111_2222_3333_4444_5555_6666_0001_0203, 1, 1'b0);
        pkt(128'hDEAD_BEEF_0000_0001_CAFE_F00D_12FF_0055,
            128'hDEAD_BEEF_0000_0001_CAFE_F00D_00FF_0055, 2, 1'b0);
        // two single-beat packets back to back
        pkt(128'h0000_0000_0000_0000_0000_0000_0100_0001,
            128'h0000_0000_0000_0000_0000_0000_0000_0001, 1, 1'b0);
        pkt(128'h0000_0000_0000_0000_0000_0000_0200_0002,
            128'h0000_0000_0000_0000_0000_0000_0000_0002, 1, 1'b0);
        idle(2);

        // SOP stalled 4 cycles with a shifting tuser; only the transfer-cycle value counts
        for (int i = 0; i < 4; i++)
            beat(1'b1, 1'b0, 1'b0, 128'h5500 + 128'(i), 1'b0, '0);
        beat(1'b1, 1'b1, 1'b0, 128'h0000_0000_0000_0000_0000_0000_0300_00B0, 1'b1,
             128'h0000_0000_0000_0000_0000_0000_0000_00B0);
        beat(1'b1, 1'b0, 1'b1, 128'hBAD, 1'b0, '0);
        beat(1'b1, 1'b1, 1'b1, 128'hBAD, 1'b0, '0);
        idle(2);

        // reset during beat 2 of a 4-beat packet; old beat 3 becomes a new SOP
        beat(1'b1, 1'b1, 1'b0, 128'h0900_0011, 1'b1, 128'h0000_0011);
        arst = 1'b0;
        beat(1'b1, 1'b1, 1'b0, 128'h0900_0011, 1'b0, '0);
        chk("midrst_valid", {127'd0, vld_c}, 128'd0);
        chk("midrst_data", dat_c, 128'd0);
        chk("midrst_data_raw", dat_r, 128'd0);
        arst = 1'b1;
        beat(1'b1, 1'b1, 1'b0, 128'h0A00_0033, 1'b1, 128'h0000_0033);
        beat(1'b1, 1'b1, 1'b1, 128'h0A00_0033, 1'b0, '0);
        idle(2);

        // full dst byte: cleared on one instance, passed on the other
        pkt(128'hFF00_0000, 128'h0, 2, 1'b0);
        idle(2);
        chk("hold_clr", dat_c, 128'h0);
        chk("hold_raw", dat_r, 128'hFF00_0000);

`ifdef TUSER_IN_STATS_EN
        arst = 1'b0;
        idle(1);
        arst = 1'b1;
        for (int k = 1; k <= 5; k++) pkt(128'(k), 128'(k), 3, (k == 3));
        idle(2);
        chk("pkt_cnt", 128'(pkt_c), 128'd5);
        chk("err_cnt", 128'(err_c), 128'd1);
        force dut.tin_pkt_cnt = 32'hFFFF_FFFF;
        idle(1);
        release dut.tin_pkt_cnt;
        pkt(128'h77, 128'h77, 2, 1'b0);
        idle(2);
        chk("pkt_cnt_wrap", 128'(pkt_c), 128'd0);
        chk("err_cnt_hold", 128'(err_c), 128'd1);
`endif

        idle(3);
        chk("scoreboard_empty", 128'(q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tuser_in_fsm.md
Name: tuser_in_fsm

Overview:
- Ingress-side companion of the SDNet tuple-to-tuser mapper.
- Watches the AXI4-Stream packet stream entering the SDNet engine and captures the 128-bit AXIS tuser sideband on the first accepted beat of each packet.
- Presents the captured tuser to the engine's tuple input as a one-cycle tuple-valid pulse.
- Sits between the NetFPGA input arbiter / AXIS source and the SDNet tuple-in port.

Parameters:
- DATA_WIDTH, 256, AXIS tdata width; monitored only, never modified.
- TUSER_WIDTH, 128, AXIS tuser width and tuple width.
- CLEAR_DST, 1, when 1 force tuple bits [31:24] (dst_port field) to zero; when 0 pass tuser through unchanged.

Ports:
- tin_aclk  input  1  single clock for all logic.
- tin_arst  input  1  reset, synchronous, active-low (0 = reset, sampled on rising tin_aclk).
- tin_avalid  input  1  AXIS tvalid from source.
- tin_aready  input  1  AXIS tready from SDNet engine; a beat transfers when tin_avalid & tin_aready.
- tin_alast  input  1  AXIS tlast.
- tin_adata  input  DATA_WIDTH  AXIS tdata; monitor only.
- tin_atuser  input  TUSER_WIDTH  AXIS tuser; meaningful on the first beat of a packet.
- tin_valid  output  1  tuple valid pulse to the SDNet tuple input.
- tin_data  output  TUSER_WIDTH  tuple data to the SDNet tuple input.

Behaviour:
- Transfer definition: xfer = tin_avalid & tin_aready. Beats with tin_avalid=1 and tin_aready=0 are ignored; the FSM holds its state.
- FSM states: IDLE (waiting for SOP) and PKT (inside a packet).
- IDLE, xfer & !tin_alast: capture tuser and go to PKT.
- IDLE, xfer & tin_alast (single-beat packet): capture tuser and stay in IDLE.
- IDLE, no xfer: stay in IDLE.
- PKT, xfer & tin_alast: go to IDLE. No capture.
- PKT, any other beat: stay in PKT. No capture.
- Capture: register tin_data <= tin_atuser. If CLEAR_DST=1, bits [31:24] of the captured value are 0.
- Capture also sets tin_valid <= 1 for exactly the next cycle. Latency is 1 cycle from the SOP transfer edge to tin_valid high.
- tin_valid is 0 in every cycle not immediately following a capture.
- tin_data holds its last captured value until the next capture.
- Back-to-back packets (EOP beat then SOP beat on consecutive cycles) produce tin_valid pulses on consecutive-packet cycles with no gap lost. Two single-beat packets on consecutive cycles produce tin_valid high for 2 consecutive cycles with the respective tuples.
- Reset values: FSM = IDLE, tin_valid = 0, tin_data = 0.
- Reset mid-packet: FSM returns to IDLE. The next accepted beat after reset release is treated as SOP and captured, even if the source continues the old packet.
- tin_adata has no effect on any output.

Optional Feature:
- Macro name: TUSER_IN_STATS_EN.
- When defined, adds two outputs:
  - tin_pkt_cnt (32 bits): increments by 1 on every capture.
  - tin_err_cnt (16 bits): increments by 1 when the FSM is in PKT and a beat transfers with tin_avalid while tin_atuser differs from the captured value on a non-last beat.
- Both counters wrap modulo 2^N, reset to 0, and update one cycle after the triggering transfer.
- When undefined, neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset release, then a 3-beat packet with tuser=0x...00AA_0420_0040 and tready=1 on all beats:
  - tin_valid high for exactly 1 cycle, one cycle after beat 1.
  - tin_data = 0x...00AA_0020_0040 (CLEAR_DST=1).
  - No further pulses.
- Single-beat packet with tlast=1, immediately followed by a 2-beat packet:
  - Two tin_valid pulses on consecutive cycles.
  - tin_data carries each packet's tuser in order.
- SOP with tvalid=1 and tready=0 for 4 cycles, then tready=1:
  - No pulse during the stall.
  - tin_valid one cycle after the transfer cycle.
  - Tuser captured from the transfer cycle.
- tin_arst=0 asserted during beat 2 of a 4-beat packet, then released:
  - tin_valid=0 and tin_data=0 during reset.
  - The next transferred beat (old beat 3) is captured with a pulse.
- CLEAR_DST=0 instance, tuser=0xFF00_0000 in the low word: tin_data low word = 0xFF00_0000.
- With TUSER_IN_STATS_EN defined, 5 packets where packet 3 changes tuser on beat 2:
  - tin_pkt_cnt = 5 and tin_err_cnt = 1 at the end.
  - tin_pkt_cnt preloaded near wrap (force 0xFFFF_FFFF then one packet) -> 0.
